ps2_host_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_line_sync.sv | 35 +++
 rtl/ps2_host_tx.sv | 183 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host link (transmitter and receiver).
package ps2_pkg;

  // Host transmitter states, in the order a transfer walks through them.
  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    WAIT_FIRST,
    SEND,
    WAIT_IDLE,
    ABORT
  } state_e;

  // Frame index of the stop bit: d0..d7 at 0..7, parity at 8, stop at 9.
  localparam int FRAME_LAST = 9;

  // Default timing at a 50 MHz system clock.
  localparam int DEF_INHIBIT_CYCLES = 5000;    // 100 us clock-low request
  localparam int DEF_START_TIMEOUT  = 750000;  // 15 ms to the first device clock
  localparam int DEF_PKT_TIMEOUT    = 100000;  // 2 ms for the rest of the packet

  // PS/2 uses odd parity: the parity bit makes the count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Brings the asynchronous PS/2 clock and data lines into the system clock
// domain and flags falling edges of the PS/2 clock.
module ps2_line_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_clk_s,
  output logic o_data_s,
  output logic o_clk_fall
);

  logic [1:0] r_clk_sync;
  logic [1:0] r_data_sync;
  logic       r_clk_prev;

  // Two-flop synchronisers plus a delayed clock copy; idle lines reset high
  // so leaving reset never produces a spurious falling edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
      r_data_sync <= {r_data_sync[0], i_ps2_data};
      r_clk_prev  <= r_clk_sync[1];
    end
  end

  assign o_clk_s    = r_clk_sync[1];
  assign o_data_s   = r_data_sync[1];
  assign o_clk_fall = r_clk_prev & ~r_clk_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: requests the bus by holding the clock low,
// then shifts one command byte out on device-generated clock edges and reports
// the device acknowledge (or a timeout) on tx_done/tx_err.
//
// Handshake: a byte is taken on any clock edge where tx_valid and tx_ready are
// both high; tx_ready is high only in IDLE, tx_valid while busy is dropped, and
// tx_data need not be held after the accepting edge.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
  parameter int PKT_TIMEOUT    = DEF_PKT_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_err,
  output state_e     o_dbg_state
);

  localparam int CNT_MAX = (START_TIMEOUT > PKT_TIMEOUT) ? START_TIMEOUT : PKT_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] C_INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_START    = CNT_W'(START_TIMEOUT);
  localparam logic [CNT_W-1:0] C_PKT      = CNT_W'(PKT_TIMEOUT);
  localparam logic [3:0]       IDX_LAST   = 4'(FRAME_LAST);

  state_e              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [3:0]          r_idx;
  logic [FRAME_LAST:0] r_frame;
  logic                r_data_oe;
  logic                r_clk_oe;
  logic                r_ack;

  state_e              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic [3:0]          w_idx_nxt;
  logic [FRAME_LAST:0] w_frame_nxt;
  logic                w_data_oe_nxt;
  logic                w_clk_oe_nxt;
  logic                w_ack_nxt;

  logic                w_clk_s;
  logic                w_data_s;
  logic                w_clk_fall;
  logic                w_pkt_to;
  logic                w_done_ok;

  ps2_line_sync u_sync (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ps2_clk  (ps2_clk_in),
    .i_ps2_data (ps2_data_in),
    .o_clk_s    (w_clk_s),
    .o_data_s   (w_data_s),
    .o_clk_fall (w_clk_fall)
  );

  // Counter saturates so a stuck bus can never wrap back below a timeout.
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_pkt_to  = (r_cnt == C_PKT);
  assign w_done_ok = (r_state == WAIT_IDLE) && !w_pkt_to && w_clk_s && w_data_s;

  // State register and datapath registers; line enables are registered so the
  // open-drain controls never glitch on state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_frame   <= '0;
      r_data_oe <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_frame   <= w_frame_nxt;
      r_data_oe <= w_data_oe_nxt;
      r_clk_oe  <= w_clk_oe_nxt;
      r_ack     <= w_ack_nxt;
    end
  end

  // Next-state and datapath update; timeouts are tested before edges so a
  // fall landing on the timeout cycle still aborts.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = w_cnt_inc;
    w_idx_nxt     = r_idx;
    w_frame_nxt   = r_frame;
    w_data_oe_nxt = r_data_oe;
    w_ack_nxt     = r_ack;
    case (r_state)
      IDLE: begin
        w_cnt_nxt     = '0;
        w_idx_nxt     = '0;
        w_data_oe_nxt = 1'b0;
        if (tx_valid) begin
          w_frame_nxt = {1'b1, odd_parity(tx_data), tx_data};
          w_ack_nxt   = 1'b0;
          w_state_nxt = INHIBIT;
        end
      end
      INHIBIT: begin
        if (r_cnt == C_INH_LAST) begin
          w_data_oe_nxt = 1'b1;
          w_state_nxt   = REQ;
        end
      end
      REQ: begin
        w_cnt_nxt   = '0;
        w_state_nxt = WAIT_FIRST;
      end
      WAIT_FIRST: begin
        if (r_cnt == C_START) begin
          w_data_oe_nxt = 1'b0;
          w_state_nxt   = ABORT;
        end else if (w_clk_fall) begin
          w_data_oe_nxt = ~r_frame[0];
          w_idx_nxt     = 4'd1;
          w_cnt_nxt     = '0;
          w_state_nxt   = SEND;
        end
      end
      SEND: begin
        if (w_pkt_to) begin
          w_data_oe_nxt = 1'b0;
          w_state_nxt   = ABORT;
        end else if (w_clk_fall) begin
          if (r_idx <= IDX_LAST) begin
            w_data_oe_nxt = ~r_frame[r_idx];
            w_idx_nxt     = r_idx + 4'd1;
          end else begin
            w_ack_nxt   = ~w_data_s;
            w_state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (w_pkt_to) begin
          w_data_oe_nxt = 1'b0;
          w_state_nxt   = ABORT;
        end else if (w_clk_s && w_data_s) begin
          w_state_nxt = IDLE;
        end
      end
      ABORT: begin
        w_data_oe_nxt = 1'b0;
        w_state_nxt   = IDLE;
      end
      default: begin
        w_data_oe_nxt = 1'b0;
        w_state_nxt   = IDLE;
      end
    endcase
    w_clk_oe_nxt = (w_state_nxt == INHIBIT) || (w_state_nxt == REQ);
  end

  // Status outputs decoded from the current state.
  always_comb begin
    tx_ready = (r_state == IDLE);
    tx_done  = (r_state == ABORT) || w_done_ok;
    tx_err   = (r_state == ABORT) || (w_done_ok && !r_ack);
  end

  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on wired-AND lines, a vector
// table of transfers, and hand-written reset / busy sequences.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 20;
  localparam int STO  = 200;
  localparam int PTO  = 2000;
  localparam int HALF = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, tx_done, tx_err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low, dev_data_low;
  wire        ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  wire        ps2_data_line = ~(ps2_data_oe | dev_data_low);
  state_e     dbg_state;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_TIMEOUT(STO), .PKT_TIMEOUT(PTO)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];   // {stop, parity, d7..d0, start} as the device should see it
  logic        err_q[$];   // expected tx_err per completed transfer
  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int fall_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every tx_done pops one expected error flag.
  always @(negedge clk) begin
    if (!rst && tx_done) begin
      done_cyc = cyc;
      if (err_q.size() == 0) begin
        check("unexpected_done", 32'(tx_done), 32'd0);
      end else begin
        check("tx_err", 32'(tx_err), 32'(err_q.pop_front()));
      end
      check("oe_at_done", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
      check("ready_low_at_done", 32'(tx_ready), 32'd0);
      done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic handshake(input logic [7:0] b);
    check("ready_before_send", 32'(tx_ready), 32'd1);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom_range(0, 255));
    check("ready_drop", 32'(tx_ready), 32'd0);
  endtask

  // Counts cycles with ps2_clk_oe high; ends on the release cycle.
  task automatic measure_inhibit(input string tag);
    int   n;
    logic d_prev, d_last;
    n = 0; d_prev = 1'b0; d_last = 1'b0;
    while (ps2_clk_oe && n < 1000) begin
      d_prev = d_last;
      d_last = ps2_data_oe;
      n++;
      @(negedge clk);
    end
    check({tag, "_clk_oe_len"}, 32'(n), 32'(INH + 1));
    check({tag, "_doe_lead"}, {30'd0, d_prev, d_last}, 32'b01);
    check({tag, "_start_oe"}, 32'(ps2_data_oe), 32'd1);
  endtask

  // Device model: samples start, then issues 'falls' clock pulses, reading
  // the line just before each rising edge; the 11th pulse is the ACK edge.
  task automatic device(input int falls, input bit ack, input bit poke, output logic [10:0] got);
    got = '0;
    repeat (4) @(negedge clk);
    got[0] = ps2_data_line;
    for (int i = 0; i < falls; i++) begin
      if (i == 10 && ack) dev_data_low = 1'b1;
      repeat (2) @(negedge clk);
      if (i == 0) fall_cyc = cyc;
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (i < 10) got[i+1] = ps2_data_line;
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      if (poke && i == 5) begin
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        @(negedge clk);
        tx_valid = 1'b0;
      end
      repeat (HALF) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       exp_par;
    int         falls;
    bit         ack;
    bit         poke;
    logic       exp_err;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int          start_done, n, k;
    logic [10:0] got;
    start_done = done_cnt;
    err_q.push_back(v.exp_err);
    if (v.falls == 11) exp_q.push_back({1'b1, v.exp_par, v.data, 1'b0});
    handshake(v.data);
    measure_inhibit(tag);
    if (v.falls == 0) begin
      n = 0;
      while (!tx_done && n < 400) begin
        @(negedge clk);
        n++;
      end
      check({tag, "_start_timeout_at"}, 32'(n), 32'(STO + 1));
    end else begin
      device(v.falls, v.ack, v.poke, got);
      if (v.falls == 11) check({tag, "_frame"}, 32'(got), 32'(exp_q.pop_front()));
    end
    k = 0;
    while (done_cnt == start_done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check({tag, "_one_done"}, 32'(done_cnt - start_done), 32'd1);
    // Host sees the first fall 3 edges late, then aborts the cycle after the limit.
    if (v.falls > 0 && v.falls < 11)
      check({tag, "_pkt_timeout_at"}, 32'(done_cyc - fall_cyc), 32'(PTO + 4));
    check({tag, "_ready_after"}, 32'(tx_ready), 32'd1);
    check({tag, "_oe_after"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    if (v.poke) begin
      n = 0;
      for (int j = 0; j < 60; j++) begin
        if (ps2_clk_oe || !tx_ready) n++;
        @(negedge clk);
      end
      check({tag, "_no_second_frame"}, 32'(n), 32'd0);
    end
  endtask

  vec_t vecs[7];

  // ---------------- test sequence ----------------
  initial begin
    int          start_done;
    logic [10:0] got;
    vec_t        f4;

    vecs[0] = '{data: 8'hED, exp_par: 1'b1, falls: 11, ack: 1'b1, poke: 1'b0, exp_err: 1'b0};
    vecs[1] = '{data: 8'hFF, exp_par: 1'b1, falls: 11, ack: 1'b1, poke: 1'b0, exp_err: 1'b0};
    vecs[2] = '{data: 8'h01, exp_par: 1'b0, falls: 11, ack: 1'b1, poke: 1'b0, exp_err: 1'b0};
    vecs[3] = '{data: 8'h5A, exp_par: 1'b1, falls: 11, ack: 1'b0, poke: 1'b0, exp_err: 1'b1};
    vecs[4] = '{data: 8'h3C, exp_par: 1'b1, falls: 0,  ack: 1'b0, poke: 1'b0, exp_err: 1'b1};
    vecs[5] = '{data: 8'h96, exp_par: 1'b1, falls: 4,  ack: 1'b0, poke: 1'b0, exp_err: 1'b1};
    vecs[6] = '{data: 8'hA5, exp_par: 1'b1, falls: 11, ack: 1'b1, poke: 1'b1, exp_err: 1'b0};
    f4      = '{data: 8'hF4, exp_par: 1'b0, falls: 11, ack: 1'b1, poke: 1'b0, exp_err: 1'b0};

    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("rst_done_err", {30'd0, tx_done, tx_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of SEND: lines drop next cycle, no tx_done.
    start_done = done_cnt;
    handshake(8'h00);
    measure_inhibit("rst_mid");
    device(3, 1'b0, 1'b0, got);
    check("rst_mid_state", 32'(dbg_state), 32'(SEND));
    check("rst_mid_doe_before", 32'(ps2_data_oe), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("rst_mid_ready", 32'(tx_ready), 32'd1);
    check("rst_mid_done", 32'(tx_done), 32'd0);
    repeat (30) @(negedge clk);
    check("rst_mid_no_done", 32'(done_cnt - start_done), 32'd0);
    run_vec(f4, "after_rst");

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("err_q_empty", 32'(err_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
